// File: rtl/fpa_pkg.sv
// rtl/fpa_pkg.sv - shared FSM states, flag bit positions and IEEE constant builders for fpa_iter.
package fpa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_e;

    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INEXACT  = 0;

    // Both builders return a 64-bit word; callers keep the low 1+exp_w+man_w bits.
    function automatic logic [63:0] fpa_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] fpa_inf(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fpa_if.sv
// rtl/fpa_if.sv - operand/result handshake bundle between a producer and fpa_iter.
interface fpa_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic [W-1:0] result;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   flags;

    modport master (
        output in_valid, X, Y, out_ready,
        input  in_ready, result, out_valid, flags
    );

    modport slave (
        input  in_valid, X, Y, out_ready,
        output in_ready, result, out_valid, flags
    );
endinterface

// File: rtl/fpa_norm.sv
// rtl/fpa_norm.sv - leading-zero count and left shift, shift amount capped by limit_i.
module fpa_norm #(
    parameter  int WIDTH = 27,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [CW-1:0]    limit_i,
    output logic [CW-1:0]    shamt_o,
    output logic [WIDTH-1:0] data_o
);
    logic [CW-1:0] lzc;

    // Highest set bit wins since later iterations overwrite earlier ones.
    always_comb begin
        lzc = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) lzc = CW'(WIDTH - 1 - i);
        end
    end

    assign shamt_o = (lzc < limit_i) ? lzc : limit_i;
    assign data_o  = data_i << shamt_o;
endmodule

// File: rtl/fpa_iter.sv
// rtl/fpa_iter.sv - multi-cycle IEEE-style adder FSM; FPA_SUBNORMAL_EN enables gradual underflow.
module fpa_iter
    import fpa_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic clk,
    input logic rst,
    fpa_if.slave bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;
    localparam int EW1 = EXP_W + 1;
    localparam int CW  = $clog2(SW + 1);
    localparam int DW  = $clog2(MAN_W + 4);
    localparam logic [63:0]      QNAN64  = fpa_qnan(EXP_W, MAN_W);
    localparam logic [63:0]      INF64   = fpa_inf(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN    = QNAN64[W-1:0];
    localparam logic [W-2:0]     INF_MAG = INF64[W-2:0];
    localparam logic [EXP_W-1:0] EMAX    = '1;

    logic sx, sy;
    logic [EXP_W-1:0] ex, ey;
    logic [MAN_W-1:0] fx, fy;
    assign {sx, ex, fx} = bus.X;
    assign {sy, ey, fy} = bus.Y;

    logic x_nan, y_nan, x_snan, y_snan, x_inf, y_inf, x_zero, y_zero;
    assign x_nan  = (ex == EMAX) && (fx != '0);
    assign y_nan  = (ey == EMAX) && (fy != '0);
    assign x_snan = x_nan && !fx[MAN_W-1];
    assign y_snan = y_nan && !fy[MAN_W-1];
    assign x_inf  = (ex == EMAX) && (fx == '0);
    assign y_inf  = (ey == EMAX) && (fy == '0);

    logic x_big, sa_c, ha, hb;
    logic [EXP_W-1:0] ea_raw, eb_raw, ea_c, eb_c, diff;
    logic [MAN_W-1:0] fa, fb;
    logic [DW-1:0]    dcl;
    assign x_big  = {ex, fx} >= {ey, fy};
    assign sa_c   = x_big ? sx : sy;
    assign ea_raw = x_big ? ex : ey;
    assign eb_raw = x_big ? ey : ex;
    assign fa     = x_big ? fx : fy;
    assign fb     = x_big ? fy : fx;
`ifdef FPA_SUBNORMAL_EN
    assign x_zero = (ex == '0) && (fx == '0);
    assign y_zero = (ey == '0) && (fy == '0);
    assign ha     = (ea_raw != '0);
    assign hb     = (eb_raw != '0);
`else
    assign x_zero = (ex == '0);
    assign y_zero = (ey == '0);
    assign ha     = 1'b1;
    assign hb     = 1'b1;
`endif
    assign ea_c = ha ? ea_raw : EXP_W'(1);
    assign eb_c = hb ? eb_raw : EXP_W'(1);
    assign diff = ea_c - eb_c;
    assign dcl  = (diff > EXP_W'(MAN_W + 3)) ? DW'(MAN_W + 3) : DW'(diff);

    logic           spec_hit;
    logic [W-1:0]   spec_res;
    logic [2:0]     spec_flags;
    always_comb begin
        spec_hit   = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (x_nan || y_nan) begin
            spec_res                 = QNAN;
            spec_flags[FLAG_INVALID] = x_snan || y_snan;
        end else if (x_inf && y_inf) begin
            if (sx == sy) begin
                spec_res = bus.X;
            end else begin
                spec_res                 = QNAN;
                spec_flags[FLAG_INVALID] = 1'b1;
            end
        end else if (x_inf)             spec_res = bus.X;
        else if (y_inf)                 spec_res = bus.Y;
        else if (x_zero && y_zero)      spec_res = {sx & sy, {(W-1){1'b0}}};
        else if (x_zero)                spec_res = bus.Y;
        else if (y_zero)                spec_res = bus.X;
        else                            spec_hit = 1'b0;
    end

    state_e         state_q;
    logic           sa_q, sub_q, tiny_q, out_valid_q;
    logic [EW1-1:0] ea_q;
    logic [SW-1:0]  ma_q, mb_q;
    logic [SW:0]    sum_q;
    logic [DW-1:0]  cnt_q;
    logic [W-1:0]   result_q;
    logic [2:0]     flags_q;

    logic [SW-1:0]  align_d;
    logic [SW:0]    sum_d;
    assign align_d = {1'b0, mb_q[SW-1:2], mb_q[1] | mb_q[0]};
    assign sum_d   = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});

    logic [CW-1:0]  lim, shamt;
    logic [SW-1:0]  shifted;
`ifdef FPA_SUBNORMAL_EN
    // Never normalise below exponent 1; the leftover leading zeros make the subnormal.
    logic [EW1-1:0] em1;
    assign em1 = ea_q - EW1'(1);
    assign lim = (em1 >= EW1'(SW)) ? CW'(SW) : em1[CW-1:0];
`else
    assign lim = CW'(SW);
`endif

    fpa_norm #(.WIDTH(SW)) u_norm (
        .data_i  (sum_q[SW-1:0]),
        .limit_i (lim),
        .shamt_o (shamt),
        .data_o  (shifted)
    );

    logic [SW-1:0]  norm_m_d;
    logic [EW1-1:0] norm_e_d;
    logic           norm_s_d, norm_tiny_d;
    always_comb begin
        norm_m_d    = shifted;
        norm_e_d    = ea_q - EW1'(shamt);
        norm_s_d    = sa_q;
        norm_tiny_d = 1'b0;
        if (sum_q[SW]) begin
            norm_m_d = {sum_q[SW:2], sum_q[1] | sum_q[0]};
            norm_e_d = ea_q + EW1'(1);
        end else if (sum_q[SW-1:0] == '0) begin
            norm_m_d = '0;
            norm_e_d = '0;
            norm_s_d = 1'b0;
        end
`ifndef FPA_SUBNORMAL_EN
        else if (EW1'(shamt) >= ea_q) begin
            norm_m_d    = '0;
            norm_e_d    = '0;
            norm_tiny_d = 1'b1;
        end
`endif
    end

    logic [MAN_W+1:0] mant_r;
    logic [EW1-1:0]   e_r;
    logic [MAN_W-1:0] frac_r;
    logic             rnd_up;
    logic [W-1:0]     round_res_d;
    logic [2:0]       round_flags_d;
    always_comb begin
        rnd_up = ma_q[2] && (ma_q[1] || ma_q[0] || ma_q[3]);
        mant_r = {1'b0, ma_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        if (mant_r[MAN_W+1]) begin
            e_r    = ea_q + EW1'(1);
            frac_r = mant_r[MAN_W:1];
        end else begin
            // A clear hidden bit means the value is subnormal (or zero): exponent field 0.
            e_r    = mant_r[MAN_W] ? ea_q : '0;
            frac_r = mant_r[MAN_W-1:0];
        end
        round_flags_d               = '0;
        round_flags_d[FLAG_INEXACT] = (ma_q[2:0] != '0) || tiny_q;
        if (e_r >= {1'b0, EMAX}) begin
            round_res_d                  = {sa_q, INF_MAG};
            round_flags_d[FLAG_OVERFLOW] = 1'b1;
            round_flags_d[FLAG_INEXACT]  = 1'b1;
        end else begin
            round_res_d = {sa_q, e_r[EXP_W-1:0], frac_r};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.in_valid) begin
                    if (spec_hit) begin
                        result_q <= spec_res;
                        flags_q  <= spec_flags;
                        state_q  <= ST_DONE;
                    end else begin
                        sa_q    <= sa_c;
                        sub_q   <= sx ^ sy;
                        ea_q    <= {1'b0, ea_c};
                        ma_q    <= {ha, fa, 3'b000};
                        mb_q    <= {hb, fb, 3'b000};
                        cnt_q   <= dcl;
                        tiny_q  <= 1'b0;
                        state_q <= (dcl == '0) ? ST_ADD : ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    mb_q  <= align_d;
                    cnt_q <= cnt_q - DW'(1);
                    if (cnt_q == DW'(1)) state_q <= ST_ADD;
                end
                ST_ADD: begin
                    sum_q   <= sum_d;
                    state_q <= ST_NORM;
                end
                ST_NORM: begin
                    ma_q    <= norm_m_d;
                    ea_q    <= norm_e_d;
                    sa_q    <= norm_s_d;
                    tiny_q  <= norm_tiny_d;
                    state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    result_q    <= round_res_d;
                    flags_q     <= round_flags_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    // Special results arrive with out_valid low and raise it one cycle later.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fpa_iter.sv
// tb/tb_fpa_iter.sv - directed scoreboard bench for fpa_iter at EXP_W=8, MAN_W=23.
module tb_fpa_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpa_if #(.W(32)) bus ();

    fpa_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Latency counts clock edges after the accepting edge until out_valid is seen high.
    task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] res, input logic [2:0] flg, input int lat,
                         input int hold);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        bus.X        = x;
        bus.Y        = y;
        bus.in_valid = 1'b1;
        e.res = res;
        e.flg = flg;
        e.lat = lat;
        sb.push_back(e);
        chk($sformatf("%s/in_ready", tag), 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            seen = bus.out_valid;
        end
        e = sb.pop_front();
        chk($sformatf("%s/timeout", tag), 32'(seen), 32'd1);
        chk($sformatf("%s/latency", tag), 32'(n), 32'(e.lat));
        chk($sformatf("%s/result", tag), bus.result, e.res);
        chk($sformatf("%s/flags", tag), 32'(bus.flags), 32'(e.flg));
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s/hold_result", tag), bus.result, e.res);
            chk($sformatf("%s/hold_valid", tag), 32'(bus.out_valid), 32'd1);
            chk($sformatf("%s/hold_in_ready", tag), 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk($sformatf("%s/drop_valid", tag), 32'(bus.out_valid), 32'd0);
        chk($sformatf("%s/reready", tag), 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.X         = '0;
        bus.Y         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset/out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset/result", bus.result, 32'h0);
        chk("reset/flags", 32'(bus.flags), 32'd0);
        rst = 1'b0;

        do_op("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 3, 0);
        do_op("tie_even",     32'h3F800000, 32'h33800000, 32'h3F800000, 3'b001, 27, 0);
        do_op("inf_minus_inf",32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100, 1, 0);
        do_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b011, 3, 0);
        do_op("cancel_hold",  32'h3F800000, 32'hBF800000, 32'h00000000, 3'b000, 3, 10);
        do_op("one_plus_two", 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000, 4, 0);
        do_op("two_minus_half",32'h40000000, 32'hBF000000, 32'h3FC00000, 3'b000, 5, 0);
        do_op("tie_odd_up",   32'h3F800000, 32'h34400000, 32'h3F800002, 3'b001, 26, 0);
        do_op("sticky_cap",   32'h3F800000, 32'h30800000, 32'h3F800000, 3'b001, 29, 0);
        do_op("qnan_in",      32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b000, 1, 0);
        do_op("snan_in",      32'h7F800001, 32'h00000000, 32'h7FC00000, 3'b100, 1, 0);
        do_op("neg_inf",      32'hFF800000, 32'h3F800000, 32'hFF800000, 3'b000, 1, 0);
        do_op("nzero_nzero",  32'h80000000, 32'h80000000, 32'h80000000, 3'b000, 1, 0);
        do_op("pzero_nzero",  32'h00000000, 32'h80000000, 32'h00000000, 3'b000, 1, 0);
        do_op("zero_plus_neg",32'h00000000, 32'hBF800000, 32'hBF800000, 3'b000, 1, 0);
`ifdef FPA_SUBNORMAL_EN
        do_op("tiny_diff",    32'h00800001, 32'h80800000, 32'h00000001, 3'b000, 3, 0);
        do_op("sub_plus_sub", 32'h00000001, 32'h00000001, 32'h00000002, 3'b000, 3, 0);
`else
        do_op("tiny_diff",    32'h00800001, 32'h80800000, 32'h00000000, 3'b001, 3, 0);
        do_op("sub_plus_sub", 32'h00000001, 32'h00000001, 32'h00000000, 3'b000, 1, 0);
`endif

        // Abort a long alignment partway through with a reset pulse.
        do_op("pre_abort",    32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 3, 0);
        @(negedge clk);
        bus.X        = 32'h3F800000;
        bus.Y        = 32'h33800000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort/busy_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort/out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort/in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort/result", bus.result, 32'h0);
        chk("abort/flags", 32'(bus.flags), 32'd0);
        do_op("after_abort",  32'h40000000, 32'h40000000, 32'h40800000, 3'b000, 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpa_iter.md
FPA_ITER -- requirements
Module: fpa_iter

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands X,Y present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 X  input  W  IEEE-754-style operand A.
REQ-008 Y  input  W  IEEE-754-style operand B.
REQ-009 result  output  W  registered sum X+Y.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 flags  output  3  {invalid, overflow, inexact}, registered with result.

Function
REQ-013 The block SHALL be a FSM: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
REQ-014 in_ready SHALL equal (state==IDLE); X,Y SHALL be captured only on in_valid&&in_ready.
REQ-015 Special cases SHALL be resolved at capture and go IDLE->DONE, out_valid high 1 cycle after the accepting edge.
REQ-016 Any NaN operand, or +inf + -inf, SHALL give canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0); invalid=1 only for inf-inf or signaling-NaN input.
REQ-017 One infinite operand SHALL give that infinity; one zero operand SHALL give the other operand; +0 + -0 SHALL give +0, -0 + -0 SHALL give -0.
REQ-018 ALIGN SHALL right-shift the smaller-exponent significand one bit per cycle, ORing shifted-out bits into a sticky bit, for d' = min(|ex-ey|, MAN_W+3) cycles (0 cycles: ALIGN skipped).
REQ-019 ADD SHALL add or subtract (per signs) MAN_W+4-bit significands (hidden+fraction+guard+round+sticky) plus one carry bit in one cycle; sign taken from the larger magnitude.
REQ-020 NORM SHALL in one cycle right-shift by one on carry-out or left-shift by the leading-zero count, adjusting exponent; exact zero sum SHALL give +0.
REQ-021 ROUND SHALL apply round-to-nearest-even from guard/round/sticky; inexact=1 if any of them nonzero; mantissa overflow from rounding SHALL increment exponent.
REQ-022 Exponent reaching all ones SHALL give signed infinity with overflow=1, inexact=1.
REQ-023 Normal-path out_valid SHALL rise 3+d' cycles after the accepting edge.
REQ-024 In DONE, result/flags/out_valid SHALL hold stable until out_ready; on out_valid&&out_ready the FSM SHALL return to IDLE, in_ready rising the next cycle (no same-cycle re-accept).

Reset
REQ-025 rst SHALL force IDLE, in_ready=1 after the edge, out_valid=0, result=0, flags=0, discarding any in-flight operation, in any state.

Configuration
REQ-026 Macro FPA_SUBNORMAL_EN defined: subnormal inputs SHALL use hidden bit 0 and exponent 1; results below min normal SHALL be produced as subnormals (rounded, inexact as REQ-021).
REQ-027 FPA_SUBNORMAL_EN undefined: subnormal inputs SHALL be treated as signed zero; tiny results SHALL flush to signed zero with inexact=1 if nonzero before flushing.

Structure
REQ-028 Package fpa_pkg SHALL hold the state enum, canonical qNaN/infinity constants as functions of EXP_W/MAN_W, and the flag bit indices.
REQ-029 Sub-module fpa_norm (combinational leading-zero count plus left shift, parametrised width) SHALL be instantiated by NORM.

Verification (defaults EXP_W=8, MAN_W=23)
REQ-030 X=3F800000, Y=3F800000 -> result 40000000, flags 000, out_valid 3 cycles after accept.
REQ-031 X=3F800000, Y=33800000 -> 3F800000, inexact=1 (tie to even), out_valid 27 cycles after accept.
REQ-032 X=7F800000, Y=FF800000 -> 7FC00000, invalid=1, 1 cycle; X=7F7FFFFF, Y=7F7FFFFF -> 7F800000, overflow=1, inexact=1.
REQ-033 X=3F800000, Y=BF800000 -> 00000000; out_ready held low 10 cycles -> result stable, in_ready low throughout.
REQ-034 rst pulsed mid-ALIGN -> next cycle out_valid=0, in_ready=1; new op X=40000000, Y=40000000 -> 40800000.
REQ-035 X=00000001, Y=00000001 -> 00000002 with FPA_SUBNORMAL_EN, 00000000 without.
